// File: rtl/uart_dec_pkg.sv
// Shared constants, FSM encodings and byte classifiers for the UART decimal
// command receiver and its 8N1 front end.
package uart_dec_pkg;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_9  = 8'h39;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_QM = 8'h3F;

  localparam int unsigned DEC_MAX = 65535;

  typedef enum logic [2:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_STOP,
    R_BREAK
  } rx_state_t;

  typedef enum logic {
    P_ACCUM,
    P_DISCARD
  } parse_state_t;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ASCII_0) && (b <= ASCII_9);
  endfunction

  function automatic logic is_eol(input logic [7:0] b);
    return (b == ASCII_CR) || (b == ASCII_LF);
  endfunction

endpackage

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: 2-flop input synchronizer, mid-bit sampling FSM,
// framed-byte strobe, framing-error strobe and busy flag.
module uart_rx_8n1
  import uart_dec_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       rx_byte_valid,
  output logic       err_frame,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);

  logic             rx_meta;
  logic             rxs;
  rx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;

  // Synchronizer resets to the idle (mark) level so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= R_IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      shift         <= '0;
      rx_byte       <= '0;
      rx_byte_valid <= 1'b0;
      err_frame     <= 1'b0;
      busy          <= 1'b0;
    end else begin
      rx_byte_valid <= 1'b0;
      err_frame     <= 1'b0;
      case (state)
        R_IDLE: begin
          if (!rxs) begin
            cnt   <= HALF_BIT;
            state <= R_START;
            busy  <= 1'b1;
          end
        end
        R_START: begin
          if (cnt == '0) begin
            if (!rxs) begin
              state   <= R_DATA;
              bit_idx <= '0;
              cnt     <= FULL_BIT;
            end else begin
              state <= R_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        R_DATA: begin
          if (cnt == '0) begin
            shift   <= {rxs, shift[7:1]};
            cnt     <= FULL_BIT;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= R_STOP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        R_STOP: begin
          if (cnt == '0) begin
            if (rxs) begin
              rx_byte       <= shift;
              rx_byte_valid <= 1'b1;
              state         <= R_IDLE;
              busy          <= 1'b0;
            end else begin
              err_frame <= 1'b1;
              state     <= R_BREAK;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        R_BREAK: begin
          if (rxs) begin
            state <= R_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= R_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_dec_cmd.sv
// UART receiver plus ASCII decimal line parser ("25\r" -> 16-bit value strobe).
// Define UART_RX_DEC_CMD_ECHO_EN to add the echo_byte/echo_valid loopback port.
module uart_rx_dec_cmd
  import uart_dec_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1250,
  parameter int MAX_DIGITS   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic [7:0]  rx_byte,
  output logic        rx_byte_valid,
  output logic [15:0] value,
  output logic        value_valid,
  output logic        err_frame,
  output logic        err_parse,
`ifdef UART_RX_DEC_CMD_ECHO_EN
  output logic [7:0]  echo_byte,
  output logic        echo_valid,
`endif
  output logic        busy
);

  localparam int DW = $clog2(MAX_DIGITS + 1);

  parse_state_t pstate;
  logic [15:0]  acc;
  logic [DW-1:0] dcnt;
  logic [19:0]  next_val;
  logic         overflow;
  logic         perr_now;

  uart_rx_8n1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk           (clk),
    .rst           (rst),
    .rx            (rx),
    .rx_byte       (rx_byte),
    .rx_byte_valid (rx_byte_valid),
    .err_frame     (err_frame),
    .busy          (busy)
  );

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    next_val = 20'(acc) * 20'd10 + 20'(rx_byte - ASCII_0);
    overflow = (next_val > 20'(DEC_MAX)) || (dcnt == DW'(MAX_DIGITS));
    perr_now = rx_byte_valid && (pstate == P_ACCUM) &&
               (is_digit(rx_byte) ? overflow : !is_eol(rx_byte));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pstate      <= P_ACCUM;
      acc         <= '0;
      dcnt        <= '0;
      value       <= '0;
      value_valid <= 1'b0;
      err_parse   <= 1'b0;
    end else begin
      value_valid <= 1'b0;
      err_parse   <= perr_now;
      if (rx_byte_valid) begin
        case (pstate)
          P_ACCUM: begin
            if (perr_now) begin
              pstate <= P_DISCARD;
            end else if (is_digit(rx_byte)) begin
              acc  <= next_val[15:0];
              dcnt <= dcnt + 1'b1;
            end else begin
              // Empty lines (second half of "\r\n") clear state without a strobe.
              if (dcnt != '0) begin
                value       <= acc;
                value_valid <= 1'b1;
              end
              acc  <= '0;
              dcnt <= '0;
            end
          end
          P_DISCARD: begin
            if (is_eol(rx_byte)) begin
              acc    <= '0;
              dcnt   <= '0;
              pstate <= P_ACCUM;
            end
          end
          default: pstate <= P_ACCUM;
        endcase
      end
    end
  end

`ifdef UART_RX_DEC_CMD_ECHO_EN
  // Echo lines up with err_parse so a rejected byte is replaced by '?'.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      echo_byte  <= '0;
      echo_valid <= 1'b0;
    end else begin
      echo_valid <= rx_byte_valid;
      if (rx_byte_valid) echo_byte <= perr_now ? ASCII_QM : rx_byte;
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_dec_cmd.sv
// Directed bench for uart_rx_dec_cmd: table of ASCII lines plus hand-written
// frame-error, glitch and mid-frame reset sequences.
module tb_uart_rx_dec_cmd;

  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx  = 1'b1;
  logic [7:0]  rx_byte;
  logic        rx_byte_valid;
  logic [15:0] value;
  logic        value_valid;
  logic        err_frame;
  logic        err_parse;
  logic        busy;

  uart_rx_dec_cmd #(.CLKS_PER_BIT(CPB), .MAX_DIGITS(5)) dut (
    .clk           (clk),
    .rst           (rst),
    .rx            (rx),
    .rx_byte       (rx_byte),
    .rx_byte_valid (rx_byte_valid),
    .value         (value),
    .value_valid   (value_valid),
    .err_frame     (err_frame),
    .err_parse     (err_parse),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  int cyc = 0;
  int n_rbv, n_vv, n_perr, n_ferr;
  int last_rbv_cyc, last_vv_cyc;
  logic [7:0] perr_byte;
  logic busy_seen;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rx_byte_valid) begin n_rbv++; last_rbv_cyc = cyc; end
    if (value_valid)   begin n_vv++;  last_vv_cyc  = cyc; end
    if (err_parse)     begin n_perr++; perr_byte = rx_byte; end
    if (err_frame)     n_ferr++;
    if (busy)          busy_seen = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic clear_counts();
    n_rbv = 0; n_vv = 0; n_perr = 0; n_ferr = 0;
    perr_byte = 8'h00; busy_seen = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_line(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
    rx = 1'b1;
    repeat (4 * CPB) @(negedge clk);
  endtask

  typedef struct {
    string       msg;
    logic [15:0] exp_value;
    int          exp_vv;
    int          exp_perr;
    int          exp_rbv;
    logic [7:0]  exp_pbyte;
  } vec_t;

  vec_t tbl[11];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{"123\015",     16'd123,   1, 0, 4, 8'h00};
    tbl[1]  = '{"65535\015\n", 16'd65535, 1, 0, 7, 8'h00};
    tbl[2]  = '{"65536\015",   16'd65535, 0, 1, 6, "6"};
    tbl[3]  = '{"1a2\015",     16'd65535, 0, 1, 4, "a"};
    tbl[4]  = '{"7\n",         16'd7,     1, 0, 2, 8'h00};
    tbl[5]  = '{"123456\015",  16'd7,     0, 1, 7, "6"};
    tbl[6]  = '{"0042\015",    16'd42,    1, 0, 5, 8'h00};
    tbl[7]  = '{"000001\n",    16'd42,    0, 1, 7, "1"};
    tbl[8]  = '{"\015\n",      16'd42,    0, 0, 2, 8'h00};
    tbl[9]  = '{"12 \015",     16'd42,    0, 1, 4, " "};
    tbl[10] = '{"60000\015",   16'd60000, 1, 0, 6, 8'h00};

    clear_counts();
    repeat (3) @(negedge clk);
    check("reset_value", 32'(value), 0);
    check("reset_rx_byte", 32'(rx_byte), 0);
    check("reset_busy", 32'(busy), 0);
    rst = 1'b0;
    repeat (CPB) @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      clear_counts();
      send_line(tbl[i].msg);
      check($sformatf("v%0d_value", i), 32'(value), 32'(tbl[i].exp_value));
      check($sformatf("v%0d_value_valid_count", i), n_vv, tbl[i].exp_vv);
      check($sformatf("v%0d_err_parse_count", i), n_perr, tbl[i].exp_perr);
      check($sformatf("v%0d_rx_byte_valid_count", i), n_rbv, tbl[i].exp_rbv);
      check($sformatf("v%0d_err_frame_count", i), n_ferr, 0);
      if (tbl[i].exp_perr > 0)
        check($sformatf("v%0d_err_parse_byte", i), 32'(perr_byte), 32'(tbl[i].exp_pbyte));
      if (i == 0)
        check("v0_value_valid_latency", last_vv_cyc - last_rbv_cyc, 1);
    end

    // Framing error: stop bit low, line held low 3 more bit times.
    clear_counts();
    send_byte(8'h35, 1'b0);
    repeat (3 * CPB) @(negedge clk);
    check("break_busy_high", 32'(busy), 1);
    rx = 1'b1;
    repeat (CPB) @(negedge clk);
    check("break_busy_low", 32'(busy), 0);
    check("break_err_frame_count", n_ferr, 1);
    check("break_rx_byte_valid_count", n_rbv, 0);
    clear_counts();
    send_line("9\015");
    check("after_break_value", 32'(value), 9);
    check("after_break_vv_count", n_vv, 1);

    // Start-bit glitch shorter than half a bit.
    clear_counts();
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("glitch_busy_seen", 32'(busy_seen), 1);
    check("glitch_busy_low", 32'(busy), 0);
    check("glitch_strobes", n_rbv + n_vv + n_ferr + n_perr, 0);

    // Reset during bit 4 of '5' after "1" was accepted.
    send_line("1");
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = ((8'h35 >> i) & 8'h01) != 0;
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_value", 32'(value), 0);
    check("rst_rx_byte", 32'(rx_byte), 0);
    check("rst_strobes", 32'({rx_byte_valid, value_valid, err_frame, err_parse}), 0);
    check("rst_busy", 32'(busy), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (CPB) @(negedge clk);
    clear_counts();
    send_line("8\015");
    check("after_rst_value", 32'(value), 8);
    check("after_rst_vv_count", n_vv, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
